// File: rtl/seg7_scan_driver_pkg.sv
// Shared seven-segment definitions: segment vector type, blank code and the
// hex glyph table (bit6=a ... bit0=g, active-high).
package seg7_scan_driver_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

  localparam seg_t SEG_HEX [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-stage bus: nibble/strobe controls in, shared segment bus and digit select out.
interface seg7_scan_driver_if
  import seg7_scan_driver_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NUM_DIGITS = 4
);
  logic [WIDTH-1:0]      din;
  logic                  load;
  logic                  clear;
  logic                  enable;
  seg_t                  seg;
  logic [NUM_DIGITS-1:0] dig_sel;

  modport master (output din, load, clear, enable, input seg, dig_sel);
  modport slave  (input din, load, clear, enable, output seg, dig_sel);
endinterface

// File: rtl/seg7_scan_driver_decode.sv
// Combinational hex-nibble to seven-segment lookup; unknown input decodes to blank.
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  // Table lookup; the default arm catches X/Z nibbles
  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_HEX[0];
      4'h1: seg_o = SEG_HEX[1];
      4'h2: seg_o = SEG_HEX[2];
      4'h3: seg_o = SEG_HEX[3];
      4'h4: seg_o = SEG_HEX[4];
      4'h5: seg_o = SEG_HEX[5];
      4'h6: seg_o = SEG_HEX[6];
      4'h7: seg_o = SEG_HEX[7];
      4'h8: seg_o = SEG_HEX[8];
      4'h9: seg_o = SEG_HEX[9];
      4'hA: seg_o = SEG_HEX[10];
      4'hB: seg_o = SEG_HEX[11];
      4'hC: seg_o = SEG_HEX[12];
      4'hD: seg_o = SEG_HEX[13];
      4'hE: seg_o = SEG_HEX[14];
      4'hF: seg_o = SEG_HEX[15];
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Captures ALU result nibbles into a shift history (newest in digit 0) and
// time-multiplexes them onto a shared segment bus with a one-hot digit select.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [WIDTH-1:0]      digit_q [NUM_DIGITS];
  logic [WIDTH-1:0]      digit_d [NUM_DIGITS];
  logic [CW-1:0]         valid_cnt_q, valid_cnt_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  seg_t                  seg_q, seg_d, dec_seg;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

  seg7_decode u_decode (
    .nib_i (digit_q[idx_q]),
    .seg_o (dec_seg)
  );

  // History shift register and fill count; clear overrides load
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = digit_q[i];
    valid_cnt_d = valid_cnt_q;
    if (bus.clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = '0;
      valid_cnt_d = '0;
    end else if (bus.load) begin
      digit_d[0] = bus.din;
      for (int i = 1; i < NUM_DIGITS; i++) digit_d[i] = digit_q[i-1];
      if (valid_cnt_q != CW'(NUM_DIGITS)) begin
        valid_cnt_d = valid_cnt_q + CW'(1);
      end else begin
        valid_cnt_d = valid_cnt_q;
      end
    end else begin
      valid_cnt_d = valid_cnt_q;
    end
  end

  // Prescaler and scan index; the index steps once per prescaler wrap
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      if (idx_q == IW'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Next output word; unfilled positions keep their select but show blank
  always_comb begin
    seg_d     = SEG_BLANK;
    dig_sel_d = '0;
    if (bus.enable) begin
      dig_sel_d = NUM_DIGITS'(1) << idx_q;
      if (32'(idx_q) < 32'(valid_cnt_q)) begin
        seg_d = dec_seg;
      end else begin
        seg_d = SEG_BLANK;
      end
    end else begin
      dig_sel_d = '0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      valid_cnt_q <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_BLANK;
      dig_sel_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
      valid_cnt_q <= valid_cnt_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      dig_sel_q   <= dig_sel_d;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed plus randomized bench for seg7_scan_driver against a queue-based display model.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  seg7_scan_driver_if #(.WIDTH(4), .NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(.WIDTH(4), .NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] lut [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  int         hist [$];
  int         tick = 0;
  logic [6:0] exp_seg = 7'h00;
  logic [N-1:0] exp_sel = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, update the model at the edge, check on the falling edge
  task automatic step(input logic r, input logic ld, input logic [3:0] d,
                      input logic clr, input logic en, input string tag);
    int idx;
    rst_n      = r;
    bus.load   = ld;
    bus.din    = d;
    bus.clear  = clr;
    bus.enable = en;
    @(posedge clk);
    if (!r) begin
      hist.delete();
      tick    = 0;
      exp_seg = 7'h00;
      exp_sel = '0;
    end else begin
      idx = (tick / SD) % N;
      if (en) begin
        exp_sel = N'(1) << idx;
        exp_seg = (idx < hist.size()) ? lut[hist[idx]] : 7'h00;
      end else begin
        exp_sel = '0;
        exp_seg = 7'h00;
      end
      if (clr) hist.delete();
      else if (ld) begin
        hist.push_front(int'(d));
        if (hist.size() > N) void'(hist.pop_back());
      end
      tick++;
    end
    @(negedge clk);
    chk({tag, ".seg"}, 32'(bus.seg), 32'(exp_seg));
    chk({tag, ".sel"}, 32'(bus.dig_sel), 32'(exp_sel));
    chk({tag, ".onehot"}, 32'($countones(bus.dig_sel) <= 1), 32'd1);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    // 1. reset with load held high
    step(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, "reset");
    step(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, "reset");
    chk("reset.seg0", 32'(bus.seg), 32'h0);
    chk("reset.sel0", 32'(bus.dig_sel), 32'h0);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, "release");
    chk("release.sel", 32'(bus.dig_sel), 32'h1);
    chk("release.seg", 32'(bus.seg), 32'h0);

    // 2. three loads then idle through two full scans
    step(1'b1, 1'b1, 4'h1, 1'b0, 1'b1, "load");
    step(1'b1, 1'b1, 4'h2, 1'b0, 1'b1, "load");
    step(1'b1, 1'b1, 4'h3, 1'b0, 1'b1, "load");
    idle(16, "scan3");

    // 3. saturation and shift-out
    for (int v = 0; v < 5; v++) step(1'b1, 1'b1, 4'(v), 1'b0, 1'b1, "sat");
    idle(16, "sat_scan");

    // 4. clear wins over load
    step(1'b1, 1'b1, 4'hF, 1'b1, 1'b1, "clrload");
    idle(10, "clr_scan");

    // 5. enable gating mid-scan
    for (int v = 0; v < 4; v++) step(1'b1, 1'b1, 4'($urandom_range(15)), 1'b0, 1'b1, "fill");
    idle(3, "pre_gate");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "gate");
    idle(10, "resume");

    // 6. decode sweep through digit 0
    for (int v = 0; v < 16; v++) begin
      step(1'b1, 1'b1, 4'(v), 1'b0, 1'b1, "sweep_ld");
      idle(8, "sweep");
    end

    // randomized traffic including occasional mid-scan resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(60) != 0), ($urandom_range(2) == 0), 4'($urandom_range(15)),
           ($urandom_range(25) == 0), ($urandom_range(7) != 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
